// File: rtl/cla_seq_adder.sv
// Sequential multi-word adder/subtractor: one WIDTH-bit lookahead slice is reused once per
// chunk, least significant chunk first, with the carry held in a register between chunks.
module cla_seq_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op_sub,
  input  logic [WIDTH*NWORDS-1:0] a,
  input  logic [WIDTH*NWORDS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*NWORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int unsigned TotW = WIDTH * NWORDS;
  localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [TotW-1:0] a_q, a_d;
  logic [TotW-1:0] b_q, b_d;
  logic [TotW-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // Bit offset of the chunk currently being processed.
  int unsigned base;
  assign base = 32'(idx_q) * WIDTH;

  logic [WIDTH-1:0] sl_a, sl_b, sl_s, gen, prop;
  logic [WIDTH:0]   c;

  // Single adder slice: generate/propagate with a carry chain; c[i] is the carry into bit i.
  always_comb begin
    logic carry;
    sl_a  = a_q[base +: WIDTH];
    sl_b  = b_q[base +: WIDTH];
    gen   = sl_a & sl_b;
    prop  = sl_a ^ sl_b;
    carry = carry_q;
    c     = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      c[i]  = carry;
      carry = gen[i] | (prop[i] & carry);
    end
    c[WIDTH] = carry;
    sl_s     = prop ^ c[WIDTH-1:0];
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          // Subtraction is A + ~B + 1.
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: WIDTH] = sl_s;
        carry_d              = c[WIDTH];
        idx_d                = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = c[WIDTH];
          ovf_d   = c[WIDTH] ^ c[WIDTH-1];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun) || (state_q == StDone);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: scoreboard of full-width arithmetic results checked by a monitor.
`timescale 1ns/1ps
module tb_cla_seq_adder;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start, op_sub, cin;
  logic [31:0] a, b, sum;
  logic        busy, done, cout, ovf;

  logic        start1, op_sub1, cin1;
  logic [31:0] a1, b1, sum1;
  logic        busy1, done1, cout1, ovf1;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(8), .NWORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_seq_adder #(.WIDTH(32), .NWORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          next_ok = 0;
  int          done_cnt = 0;
  bit          have_last = 0;
  logic [31:0] last_s;
  logic        last_co, last_ov;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: exact integer arithmetic on the 32-bit operands.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic ci,
                                input logic sub, output logic [31:0] s, output logic co,
                                output logic ov);
    longint          sx, sy, r;
    longint unsigned u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sub) begin
      r  = sx - sy;
      co = (x >= y);
    end else begin
      r  = sx + sy + longint'(ci);
      u  = 64'(x) + 64'(y) + 64'(ci);
      co = (u >= 64'h1_0000_0000);
    end
    s  = r[31:0];
    ov = (r != longint'($signed(s)));
  endfunction

  // Acceptance model: an operation occupies NWORDS+2 cycles from its accept edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      next_ok = 0;
    end else if (start && cyc >= next_ok) begin
      model(a, b, cin, op_sub, e.s, e.co, e.ov);
      e.due   = cyc + N;
      q.push_back(e);
      next_ok = cyc + N + 2;
    end
  end

  // Monitor: compare results on done, busy against pending work, and held outputs when idle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, q.size() != 0);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          mon_e = q.pop_front();
          done_cnt++;
          chk("done_cycle", cyc, mon_e.due);
          chk("sum", sum, mon_e.s);
          chk("cout", cout, mon_e.co);
          chk("ovf", ovf, mon_e.ov);
          last_s    = mon_e.s;
          last_co   = mon_e.co;
          last_ov   = mon_e.ov;
          have_last = 1;
        end
      end else begin
        if (q.size() != 0 && cyc >= q[0].due) begin
          checks++;
          failures++;
          $display("FAIL missing_done: got done=0 expected done at cycle %0d", q[0].due);
          void'(q.pop_front());
        end
        if (q.size() == 0 && have_last) begin
          chk("hold_sum", sum, last_s);
          chk("hold_cout", cout, last_co);
          chk("hold_ovf", ovf, last_ov);
        end
      end
    end
  end

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  // Issue one operation, then scramble operands so late changes must not matter.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic sub);
    wait_drain();
    a      = x;
    b      = y;
    cin    = ci;
    op_sub = sub;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    cin    = 1'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic issue1(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sub);
    logic [31:0] s;
    logic        co, ov;
    model(x, y, ci, sub, s, co, ov);
    a1      = x;
    b1      = y;
    cin1    = ci;
    op_sub1 = sub;
    start1  = 1'b1;
    @(posedge clk);
    #1;
    start1  = 1'b0;
    a1      = $urandom;
    b1      = $urandom;
    @(negedge clk);
    chk("n1_run_done", done1, 1'b0);
    chk("n1_run_busy", busy1, 1'b1);
    @(negedge clk);
    chk("n1_done", done1, 1'b1);
    chk("n1_sum", sum1, s);
    chk("n1_cout", cout1, co);
    chk("n1_ovf", ovf1, ov);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    start = 0; op_sub = 0; cin = 0; a = 0; b = 0;
    start1 = 0; op_sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_sum1", sum1, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed corner cases.
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      issue($urandom, $urandom, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // start held every cycle for 20 cycles with changing operands.
    wait_drain();
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      a      = $urandom;
      b      = $urandom;
      cin    = 1'($urandom);
      op_sub = 1'($urandom);
      start  = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_drain();
    chk("burst_done_count", done_cnt - d0, 4);

    // Reset during the second RUN cycle aborts the operation.
    wait_drain();
    a = 32'h1122_3344; b = 32'h0101_0101; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    next_ok   = 0;
    have_last = 0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum", sum, 32'h0);
    chk("abort_cout", cout, 1'b0);
    chk("abort_ovf", ovf, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
    wait_drain();

    // Single-chunk configuration.
    issue1(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue1(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    issue1(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
    issue1($urandom, $urandom, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
